// File: rtl/byteswap_axi_mem_responder_if.sv
// rtl/byteswap_axi_mem_responder_if.sv - AXI4 read/write subset bus between byteswap master and memory responder
interface byteswap_axi_mem_responder_if #(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 512
);
   logic                            s_axi_awvalid;
   logic                            s_axi_awready;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr;
   logic [7:0]                      s_axi_awlen;
   logic                            s_axi_wvalid;
   logic                            s_axi_wready;
   logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_wdata;
   logic [C_M_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb;
   logic                            s_axi_wlast;
   logic                            s_axi_bvalid;
   logic                            s_axi_bready;
   logic                            s_axi_arvalid;
   logic                            s_axi_arready;
   logic [C_M_AXI_ADDR_WIDTH-1:0]   s_axi_araddr;
   logic [7:0]                      s_axi_arlen;
   logic                            s_axi_rvalid;
   logic                            s_axi_rready;
   logic [C_M_AXI_DATA_WIDTH-1:0]   s_axi_rdata;
   logic                            s_axi_rlast;

   modport master (
      output s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
      output s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      output s_axi_bready,
      output s_axi_arvalid, s_axi_araddr, s_axi_arlen,
      output s_axi_rready,
      input  s_axi_awready, s_axi_wready, s_axi_bvalid,
      input  s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast
   );

   modport slave (
      input  s_axi_awvalid, s_axi_awaddr, s_axi_awlen,
      input  s_axi_wvalid, s_axi_wdata, s_axi_wstrb, s_axi_wlast,
      input  s_axi_bready,
      input  s_axi_arvalid, s_axi_araddr, s_axi_arlen,
      input  s_axi_rready,
      output s_axi_awready, s_axi_wready, s_axi_bvalid,
      output s_axi_arready, s_axi_rvalid, s_axi_rdata, s_axi_rlast
   );
endinterface

// File: rtl/byteswap_axi_mem_responder.sv
// rtl/byteswap_axi_mem_responder.sv - AXI4 INCR memory responder backed by an on-chip word array
// Optional ready-stall LFSR enabled by defining BYTESWAP_AXI_MEM_STALL_EN.
module byteswap_axi_mem_responder #(
   parameter int          C_M_AXI_ADDR_WIDTH = 64,
   parameter int          C_M_AXI_DATA_WIDTH = 512,
   parameter int          C_MEM_DEPTH        = 1024,
   parameter logic [15:0] C_LFSR_SEED        = 16'hACE1
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   byteswap_axi_mem_responder_if.slave s_axi,
   output logic                        err_wlast
);
   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int OFF_W = $clog2(BYTES);
   localparam int IDX_W = $clog2(C_MEM_DEPTH);

   typedef logic [IDX_W-1:0] idx_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_BURST} r_state_t;

   logic [1:0] rst_sync;
   logic       rst_n;
   logic       ready_ok;
   w_state_t   w_state, w_next;
   r_state_t   r_state, r_next;
   idx_t       w_idx, r_idx, ar_idx;
   logic [7:0] w_cnt, r_cnt;
   logic       aw_hs, w_hs, ar_hs, r_hs;
   logic [C_M_AXI_DATA_WIDTH-1:0] rdata_q;
   logic [C_M_AXI_DATA_WIDTH-1:0] mem [C_MEM_DEPTH];
   logic       unused_addr_bits;

   // Reset asserts asynchronously but is released two clocks after aresetn rises.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) rst_sync <= 2'b00;
      else          rst_sync <= {rst_sync[0], 1'b1};
   end
   assign rst_n = rst_sync[1];

`ifdef BYTESWAP_AXI_MEM_STALL_EN
   logic [15:0] lfsr;
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) lfsr <= C_LFSR_SEED;
      else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end
   assign ready_ok = lfsr[0];
`else
   assign ready_ok = 1'b1;
`endif

   assign s_axi.s_axi_awready = (w_state == W_IDLE) && ready_ok;
   assign s_axi.s_axi_wready  = (w_state == W_DATA) && ready_ok;
   assign s_axi.s_axi_bvalid  = (w_state == W_RESP);
   assign s_axi.s_axi_arready = (r_state == R_IDLE) && ready_ok;
   assign s_axi.s_axi_rvalid  = (r_state == R_BURST);
   assign s_axi.s_axi_rlast   = (r_state == R_BURST) && (r_cnt == 8'd0);
   assign s_axi.s_axi_rdata   = rdata_q;

   assign aw_hs  = s_axi.s_axi_awvalid && s_axi.s_axi_awready;
   assign w_hs   = s_axi.s_axi_wvalid  && s_axi.s_axi_wready;
   assign ar_hs  = s_axi.s_axi_arvalid && s_axi.s_axi_arready;
   assign r_hs   = s_axi.s_axi_rvalid  && s_axi.s_axi_rready;
   assign ar_idx = s_axi.s_axi_araddr[IDX_W+OFF_W-1:OFF_W];
   assign unused_addr_bits = ^{s_axi.s_axi_awaddr, s_axi.s_axi_araddr};

   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         w_state <= W_IDLE;
         r_state <= R_IDLE;
      end else begin
         w_state <= w_next;
         r_state <= r_next;
      end
   end

   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (aw_hs) w_next = W_DATA;
         W_DATA:  if (w_hs && (w_cnt == 8'd0)) w_next = W_RESP;
         W_RESP:  if (s_axi.s_axi_bready) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_BURST;
         R_BURST: if (r_hs && (r_cnt == 8'd0)) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   // The beat counter, not wlast, ends the burst; wlast only feeds the sticky error.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         w_idx     <= '0;
         w_cnt     <= 8'd0;
         err_wlast <= 1'b0;
      end else if (aw_hs) begin
         w_idx <= s_axi.s_axi_awaddr[IDX_W+OFF_W-1:OFF_W];
         w_cnt <= s_axi.s_axi_awlen;
      end else if (w_hs) begin
         w_idx <= w_idx + idx_t'(1);
         w_cnt <= w_cnt - 8'd1;
         if (s_axi.s_axi_wlast != (w_cnt == 8'd0)) err_wlast <= 1'b1;
      end
   end

   always_ff @(posedge aclk) begin
      if (w_hs) begin
         for (int b = 0; b < BYTES; b++) begin
            if (s_axi.s_axi_wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.s_axi_wdata[b*8 +: 8];
         end
      end
   end

   // r_idx points at the word to load on the next accepted beat; a same-cycle write is seen next time.
   always_ff @(posedge aclk or negedge rst_n) begin
      if (!rst_n) begin
         r_idx   <= '0;
         r_cnt   <= 8'd0;
         rdata_q <= '0;
      end else if (ar_hs) begin
         rdata_q <= mem[ar_idx];
         r_idx   <= ar_idx + idx_t'(1);
         r_cnt   <= s_axi.s_axi_arlen;
      end else if (r_hs && (r_cnt != 8'd0)) begin
         rdata_q <= mem[r_idx];
         r_idx   <= r_idx + idx_t'(1);
         r_cnt   <= r_cnt - 8'd1;
      end
   end
endmodule

// File: tb/tb_byteswap_axi_mem_responder.sv
// tb/tb_byteswap_axi_mem_responder.sv - self-checking bench for byteswap_axi_mem_responder
module tb_byteswap_axi_mem_responder;
   localparam int DEPTH = 1024;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic err_wlast;

   byteswap_axi_mem_responder_if #(.C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(512)) axi ();

   byteswap_axi_mem_responder #(
      .C_M_AXI_ADDR_WIDTH(64), .C_M_AXI_DATA_WIDTH(512), .C_MEM_DEPTH(DEPTH), .C_LFSR_SEED(16'hACE1)
   ) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axi(axi), .err_wlast(err_wlast)
   );

   always #5 aclk = ~aclk;

   typedef struct {
      bit           is_wr;
      logic [63:0]  addr;
      int           len;
      int           dkind;
      logic [63:0]  strb;
      int           bad;
      logic [31:0]  rmask;
      int           exp_cycles;
      bit           chk_last;
      logic [511:0] exp_last;
      bit           exp_err;
   } vec_t;

   logic [511:0] ref_mem [DEPTH];
   bit           ref_err;
   logic [511:0] wd [256];
   logic [63:0]  ws [256];
   int           n_pass = 0;
   int           n_total = 0;

   task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, exp);
   endtask

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
      return v;
   endfunction

   task automatic do_write(input logic [63:0] addr, input int len, input int bad);
      int t;
      int base;
      base = int'(addr[15:6]);
      axi.s_axi_awaddr  = addr;
      axi.s_axi_awlen   = 8'(len);
      axi.s_axi_awvalid = 1'b1;
      t = 0;
      while (!axi.s_axi_awready && t < 1000) begin @(negedge aclk); t++; end
      if (t >= 1000) chk("aw_timeout", 1'b0, 1'b1);
      @(negedge aclk);
      axi.s_axi_awvalid = 1'b0;
      for (int i = 0; i <= len; i++) begin
         axi.s_axi_wvalid = 1'b1;
         axi.s_axi_wdata  = wd[i];
         axi.s_axi_wstrb  = ws[i];
         axi.s_axi_wlast  = (i == len) ^ (i == bad);
         t = 0;
         while (!axi.s_axi_wready && t < 1000) begin @(negedge aclk); t++; end
         if (t >= 1000) chk("w_timeout", 1'b0, 1'b1);
         if (i == len) chk("b_early", axi.s_axi_bvalid, 1'b0);
         for (int b = 0; b < 64; b++)
            if (ws[i][b]) ref_mem[(base + i) % DEPTH][b*8 +: 8] = wd[i][b*8 +: 8];
         if (i == bad) ref_err = 1'b1;
         @(negedge aclk);
      end
      axi.s_axi_wvalid = 1'b0;
      axi.s_axi_wlast  = 1'b0;
      chk("b_latency", axi.s_axi_bvalid, 1'b1);
      @(negedge aclk);
      chk("b_done", axi.s_axi_bvalid, 1'b0);
      chk("err_wlast", err_wlast, ref_err);
   endtask

   task automatic do_read(input logic [63:0] addr, input int len, input logic [31:0] mask,
                          output int cycles, output logic [511:0] last_data);
      int t, beat, cyc, base;
      bit held;
      logic [511:0] prev_d;
      logic prev_l;
      base = int'(addr[15:6]);
      held = 1'b0;
      prev_d = '0;
      prev_l = 1'b0;
      last_data = '0;
      axi.s_axi_araddr  = addr;
      axi.s_axi_arlen   = 8'(len);
      axi.s_axi_arvalid = 1'b1;
      t = 0;
      while (!axi.s_axi_arready && t < 1000) begin @(negedge aclk); t++; end
      if (t >= 1000) chk("ar_timeout", 1'b0, 1'b1);
      @(negedge aclk);
      axi.s_axi_arvalid = 1'b0;
      chk("r_first", axi.s_axi_rvalid, 1'b1);
      beat = 0;
      cyc = 0;
      while (beat <= len && cyc < 2000) begin
         if (axi.s_axi_rvalid) begin
            if (held) begin
               chk("r_hold_data", axi.s_axi_rdata, prev_d);
               chk("r_hold_last", axi.s_axi_rlast, prev_l);
            end
            if (!mask[cyc % 32]) begin
               axi.s_axi_rready = 1'b1;
               chk("r_data", axi.s_axi_rdata, ref_mem[(base + beat) % DEPTH]);
               chk("r_last", axi.s_axi_rlast, beat == len);
               last_data = axi.s_axi_rdata;
               beat++;
               held = 1'b0;
            end else begin
               axi.s_axi_rready = 1'b0;
               held = 1'b1;
               prev_d = axi.s_axi_rdata;
               prev_l = axi.s_axi_rlast;
            end
         end else begin
            axi.s_axi_rready = 1'b0;
         end
         cyc++;
         @(negedge aclk);
      end
      axi.s_axi_rready = 1'b0;
      if (beat <= len) chk("r_timeout", 1'b0, 1'b1);
      chk("r_end", axi.s_axi_rvalid, 1'b0);
      cycles = cyc;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[11];
      int cycles;
      logic [511:0] last;
      logic [63:0] a;
      int len;

      axi.s_axi_awvalid = 0; axi.s_axi_awaddr = '0; axi.s_axi_awlen = '0;
      axi.s_axi_wvalid = 0; axi.s_axi_wdata = '0; axi.s_axi_wstrb = '0; axi.s_axi_wlast = 0;
      axi.s_axi_bready = 1; axi.s_axi_arvalid = 0; axi.s_axi_araddr = '0; axi.s_axi_arlen = '0;
      axi.s_axi_rready = 0;
      ref_err = 1'b0;

      tbl[0]  = '{1, 64'h0,    3, 0, '1, -1, 32'h0, 0, 0, '0, 0};
      tbl[1]  = '{0, 64'h0,    3, 0, '0, -1, 32'h0, 4, 1, 512'd3, 0};
      tbl[2]  = '{1, 64'd320,  0, 2, '1, -1, 32'h0, 0, 0, '0, 0};
      tbl[3]  = '{1, 64'd320,  0, 3, 64'hF, -1, 32'h0, 0, 0, '0, 0};
      tbl[4]  = '{0, 64'd320,  0, 0, '0, -1, 32'h0, 1, 1, {{60{8'hFF}}, 32'h0}, 0};
      tbl[5]  = '{1, 64'd1024, 7, 1, '1, -1, 32'h0, 0, 0, '0, 0};
      tbl[6]  = '{0, 64'd1024, 7, 0, '0, -1, 32'h66666666, 16, 0, '0, 0};
      tbl[7]  = '{1, 64'd65472, 1, 1, '1, 0, 32'h0, 0, 0, '0, 1};
      tbl[8]  = '{0, 64'd65472, 1, 0, '0, -1, 32'h0, 2, 0, '0, 1};
      tbl[9]  = '{1, 64'hFFFF_0000_0000_0A05, 2, 1, 64'h0F0F_FFFF_0000_1234, -1, 32'h0, 0, 0, '0, 1};
      tbl[10] = '{0, 64'd2560, 2, 0, '0, -1, 32'h0, 3, 0, '0, 1};

      repeat (4) @(negedge aclk);
      chk("rst_awready", axi.s_axi_awready, 1'b1);
      chk("rst_arready", axi.s_axi_arready, 1'b1);
      chk("rst_wready",  axi.s_axi_wready,  1'b0);
      chk("rst_bvalid",  axi.s_axi_bvalid,  1'b0);
      chk("rst_rvalid",  axi.s_axi_rvalid,  1'b0);
      chk("rst_rdata",   axi.s_axi_rdata,   512'd0);
      chk("rst_err",     err_wlast,         1'b0);
      aresetn = 1'b1;
      repeat (3) @(negedge aclk);

      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < 256; i++) begin wd[i] = rand512(); ws[i] = '1; end
         do_write(64'(k * 256 * 64), 255, -1);
      end

      for (int v = 0; v < 11; v++) begin
         if (tbl[v].is_wr) begin
            for (int i = 0; i <= tbl[v].len; i++) begin
               case (tbl[v].dkind)
                  0: wd[i] = 512'(i);
                  1: wd[i] = rand512();
                  2: wd[i] = '1;
                  default: wd[i] = '0;
               endcase
               ws[i] = tbl[v].strb;
            end
            do_write(tbl[v].addr, tbl[v].len, tbl[v].bad);
         end else begin
            do_read(tbl[v].addr, tbl[v].len, tbl[v].rmask, cycles, last);
            if (tbl[v].exp_cycles != 0) chk("r_cycles", 512'(cycles), 512'(tbl[v].exp_cycles));
            if (tbl[v].chk_last) chk("r_last_value", last, tbl[v].exp_last);
         end
         chk("tbl_err", err_wlast, tbl[v].exp_err);
      end

      for (int n = 0; n < 30; n++) begin
         a = {$urandom, $urandom};
         len = int'($urandom_range(0, 15));
         for (int i = 0; i <= len; i++) begin wd[i] = rand512(); ws[i] = {$urandom, $urandom}; end
         do_write(a, len, -1);
         a = {$urandom, $urandom};
         do_read(a, int'($urandom_range(0, 15)), $urandom & $urandom, cycles, last);
      end

      axi.s_axi_araddr = 64'd6400;
      axi.s_axi_arlen = 8'd15;
      axi.s_axi_arvalid = 1'b1;
      @(negedge aclk);
      axi.s_axi_arvalid = 1'b0;
      axi.s_axi_rready = 1'b1;
      repeat (5) @(negedge aclk);
      aresetn = 1'b0;
      #1;
      chk("mid_rst_rvalid", axi.s_axi_rvalid, 1'b0);
      chk("mid_rst_rlast",  axi.s_axi_rlast,  1'b0);
      chk("mid_rst_err",    err_wlast,        1'b0);
      axi.s_axi_rready = 1'b0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
      ref_err = 1'b0;
      repeat (3) @(negedge aclk);
      chk("post_rst_arready", axi.s_axi_arready, 1'b1);
      chk("post_rst_rvalid",  axi.s_axi_rvalid,  1'b0);
      do_read(64'd6400, 15, 32'h0, cycles, last);
      chk("post_rst_cycles", 512'(cycles), 512'd16);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
